// File: rtl/fetch_pkg.sv
// Shared fetch-side types and constants: the queued packet format and exception codes.
package fetch_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [7:0]  exc;
    } fetch_pkt_t;

    localparam logic [7:0]  EXC_NONE          = 8'h00;
    localparam logic [7:0]  EXC_MISALIGNED_PC = 8'h84;
    localparam logic [31:0] NOP_WORD          = 32'h0000_0000;

    // A faulting fetch must never carry live instruction bits into decode.
    function automatic fetch_pkt_t scrub_pkt(input logic [31:0] pc,
                                             input logic [31:0] instr,
                                             input logic [7:0]  exc);
        fetch_pkt_t p;
        p.pc    = pc;
        p.exc   = exc;
        p.instr = (exc != EXC_NONE) ? NOP_WORD : instr;
        return p;
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-to-decode queue bus: incoming fetch packet, decode head and throttle/status.
interface fetch_queue_if;

    logic        clk_en;
    logic        flush;
    logic        bubble_in;
    logic [31:0] pc_in;
    logic [31:0] instr_in;
    logic [7:0]  exc_in;
    logic        decode_stall;
    logic        bubble_out;
    logic [31:0] pc_out;
    logic [31:0] instr_out;
    logic [7:0]  exc_out;
    logic        stall_out;
    logic        overflow;

    modport master (
        output clk_en, flush, bubble_in, pc_in, instr_in, exc_in, decode_stall,
        input  bubble_out, pc_out, instr_out, exc_out, stall_out, overflow
    );

    modport slave (
        input  clk_en, flush, bubble_in, pc_in, instr_in, exc_in, decode_stall,
        output bubble_out, pc_out, instr_out, exc_out, stall_out, overflow
    );

endinterface

// File: rtl/fetch_queue_ram.sv
// Packet storage for the fetch queue: one write port, combinational read, contents not reset.
module fetch_queue_ram
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  fetch_pkt_t      wdata,
    input  logic [AW-1:0]   raddr,
    output fetch_pkt_t      rdata
);

    fetch_pkt_t mem_r [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction queue between fetch and decode; throttles fetch early enough to absorb
// the packets already in flight.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int SLACK = 2
) (
    input  logic          clk,
    input  logic          rst,
    fetch_queue_if.slave  q
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_C     = CW'(DEPTH);
    localparam logic [CW-1:0] THROTTLE_C = CW'(DEPTH - SLACK);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_s;
    logic          stall_r;
    logic          overflow_r;
    logic          push_s;
    logic          pop_s;
    logic          accept_s;
    logic          drop_s;
    fetch_pkt_t    head_s;

    // Handshake decode and next occupancy
    always_comb begin
        push_s   = q.clk_en & ~q.flush & ~q.bubble_in;
        pop_s    = q.clk_en & ~q.flush & ~q.decode_stall & (count_r != {CW{1'b0}});
        accept_s = push_s & ((count_r != FULL_C) | pop_s);
        drop_s   = push_s & (count_r == FULL_C) & ~pop_s;
        count_s  = count_r;
        if (!q.clk_en) begin
            count_s = count_r;
        end else if (q.flush) begin
            count_s = {CW{1'b0}};
        end else begin
            case ({accept_s, pop_s})
                2'b10:   count_s = count_r + CNT_ONE;
                2'b01:   count_s = count_r - CNT_ONE;
                default: count_s = count_r;
            endcase
        end
    end

    // Pointers, occupancy, registered throttle and sticky overflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= {CW{1'b0}};
            stall_r    <= 1'b0;
            overflow_r <= 1'b0;
        end else if (q.clk_en) begin
            if (q.flush) begin
                wr_ptr_r <= {AW{1'b0}};
                rd_ptr_r <= {AW{1'b0}};
            end else begin
                if (accept_s) begin
                    wr_ptr_r <= wr_ptr_r + PTR_ONE;
                end
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + PTR_ONE;
                end
            end
            count_r <= count_s;
            stall_r <= (count_s >= THROTTLE_C);
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    fetch_queue_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk   (clk),
        .we    (accept_s),
        .waddr (wr_ptr_r),
        .wdata (scrub_pkt(q.pc_in, q.instr_in, q.exc_in)),
        .raddr (rd_ptr_r),
        .rdata (head_s)
    );

    // Head presentation; an empty queue shows a clean bubble
    always_comb begin
        if (count_r == {CW{1'b0}}) begin
            q.bubble_out = 1'b1;
            q.pc_out     = 32'h0000_0000;
            q.instr_out  = NOP_WORD;
            q.exc_out    = EXC_NONE;
        end else begin
            q.bubble_out = 1'b0;
            q.pc_out     = head_s.pc;
            q.instr_out  = head_s.instr;
            q.exc_out    = head_s.exc;
        end
    end

    assign q.stall_out = stall_r;
    assign q.overflow  = overflow_r;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed table-driven bench for fetch_queue plus hand-written latency and async-reset sequences.
module tb_fetch_queue;

    logic clk;
    logic rst;

    fetch_queue_if fq_if ();

    fetch_queue #(.DEPTH(4), .SLACK(2)) dut (
        .clk (clk),
        .rst (rst),
        .q   (fq_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        fl;
        logic        bub;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [7:0]  exc;
        logic        ds;
        logic [74:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [31:0] iw(input logic [31:0] pc);
        return {16'hC0DE, pc[15:0]};
    endfunction

    function automatic logic [74:0] bundle(input logic b, input logic [31:0] pc,
                                           input logic [31:0] ins, input logic [7:0] exc,
                                           input logic st, input logic ov);
        return {b, pc, ins, exc, st, ov};
    endfunction

    function automatic logic [74:0] actual();
        return {fq_if.bubble_out, fq_if.pc_out, fq_if.instr_out, fq_if.exc_out,
                fq_if.stall_out, fq_if.overflow};
    endfunction

    task automatic check(input string name, input logic [74:0] act, input logic [74:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got bub=%b pc=%h ins=%h exc=%h stall=%b ovf=%b, expected bub=%b pc=%h ins=%h exc=%h stall=%b ovf=%b",
                     name, act[74], act[73:42], act[41:10], act[9:2], act[1], act[0],
                     exp[74], exp[73:42], exp[41:10], exp[9:2], exp[1], exp[0]);
        end
    endtask

    task automatic add(input logic en, input logic fl, input logic bub,
                       input logic [31:0] pc, input logic [31:0] ins, input logic [7:0] exc,
                       input logic ds, input logic e_b, input logic [31:0] e_pc,
                       input logic [31:0] e_ins, input logic [7:0] e_exc,
                       input logic e_st, input logic e_ov);
        vec_t v;
        v.en = en; v.fl = fl; v.bub = bub; v.pc = pc; v.instr = ins; v.exc = exc; v.ds = ds;
        v.exp = bundle(e_b, e_pc, e_ins, e_exc, e_st, e_ov);
        vecs.push_back(v);
    endtask

    task automatic drive(input logic en, input logic fl, input logic bub,
                         input logic [31:0] pc, input logic [31:0] ins,
                         input logic [7:0] exc, input logic ds);
        fq_if.clk_en       = en;
        fq_if.flush        = fl;
        fq_if.bubble_in    = bub;
        fq_if.pc_in        = pc;
        fq_if.instr_in     = ins;
        fq_if.exc_in       = exc;
        fq_if.decode_stall = ds;
    endtask

    initial begin
        logic [74:0] empty0;
        logic [74:0] empty1;
        empty0 = bundle(1'b1, 32'h0, 32'h0, 8'h00, 1'b0, 1'b0);
        empty1 = bundle(1'b1, 32'h0, 32'h0, 8'h00, 1'b0, 1'b1);

        // basic flow, one head per cycle
        add(1'b1, 1'b0, 1'b0, 32'h400, iw(32'h400), 8'h00, 1'b0, 1'b0, 32'h400, iw(32'h400), 8'h00, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b0, 32'h404, iw(32'h404), 8'h00, 1'b0, 1'b0, 32'h404, iw(32'h404), 8'h00, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b0, 32'h408, iw(32'h408), 8'h00, 1'b0, 1'b0, 32'h408, iw(32'h408), 8'h00, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b1, 32'h0,   32'h0,       8'h00, 1'b0, 1'b1, 32'h0,   32'h0,       8'h00, 1'b0, 1'b0);
        // throttle with decode stalled, then drain
        add(1'b1, 1'b0, 1'b0, 32'h400, iw(32'h400), 8'h00, 1'b1, 1'b0, 32'h400, iw(32'h400), 8'h00, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b0, 32'h404, iw(32'h404), 8'h00, 1'b1, 1'b0, 32'h400, iw(32'h400), 8'h00, 1'b1, 1'b0);
        add(1'b1, 1'b0, 1'b0, 32'h408, iw(32'h408), 8'h00, 1'b1, 1'b0, 32'h400, iw(32'h400), 8'h00, 1'b1, 1'b0);
        add(1'b1, 1'b0, 1'b0, 32'h40C, iw(32'h40C), 8'h00, 1'b1, 1'b0, 32'h400, iw(32'h400), 8'h00, 1'b1, 1'b0);
        add(1'b1, 1'b0, 1'b1, 32'h0,   32'h0,       8'h00, 1'b1, 1'b0, 32'h400, iw(32'h400), 8'h00, 1'b1, 1'b0);
        add(1'b1, 1'b0, 1'b1, 32'h0,   32'h0,       8'h00, 1'b0, 1'b0, 32'h404, iw(32'h404), 8'h00, 1'b1, 1'b0);
        add(1'b1, 1'b0, 1'b1, 32'h0,   32'h0,       8'h00, 1'b0, 1'b0, 32'h408, iw(32'h408), 8'h00, 1'b1, 1'b0);
        add(1'b1, 1'b0, 1'b1, 32'h0,   32'h0,       8'h00, 1'b0, 1'b0, 32'h40C, iw(32'h40C), 8'h00, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b1, 32'h0,   32'h0,       8'h00, 1'b0, 1'b1, 32'h0,   32'h0,       8'h00, 1'b0, 1'b0);
        // faulting fetch carries no instruction bits
        add(1'b1, 1'b0, 1'b0, 32'h402, 32'hDEADBEEF, 8'h84, 1'b1, 1'b0, 32'h402, 32'h0, 8'h84, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b1, 32'h0,   32'h0,       8'h00, 1'b0, 1'b1, 32'h0,   32'h0,       8'h00, 1'b0, 1'b0);
        // flush with a concurrent push
        add(1'b1, 1'b0, 1'b0, 32'h500, iw(32'h500), 8'h00, 1'b1, 1'b0, 32'h500, iw(32'h500), 8'h00, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b0, 32'h504, iw(32'h504), 8'h00, 1'b1, 1'b0, 32'h500, iw(32'h500), 8'h00, 1'b1, 1'b0);
        add(1'b1, 1'b0, 1'b0, 32'h508, iw(32'h508), 8'h00, 1'b1, 1'b0, 32'h500, iw(32'h500), 8'h00, 1'b1, 1'b0);
        add(1'b1, 1'b1, 1'b0, 32'h50C, iw(32'h50C), 8'h00, 1'b1, 1'b1, 32'h0,   32'h0,       8'h00, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b1, 32'h0,   32'h0,       8'h00, 1'b1, 1'b1, 32'h0,   32'h0,       8'h00, 1'b0, 1'b0);
        // full queue: push+pop, then overflow
        add(1'b1, 1'b0, 1'b0, 32'h600, iw(32'h600), 8'h00, 1'b1, 1'b0, 32'h600, iw(32'h600), 8'h00, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b0, 32'h604, iw(32'h604), 8'h00, 1'b1, 1'b0, 32'h600, iw(32'h600), 8'h00, 1'b1, 1'b0);
        add(1'b1, 1'b0, 1'b0, 32'h608, iw(32'h608), 8'h00, 1'b1, 1'b0, 32'h600, iw(32'h600), 8'h00, 1'b1, 1'b0);
        add(1'b1, 1'b0, 1'b0, 32'h60C, iw(32'h60C), 8'h00, 1'b1, 1'b0, 32'h600, iw(32'h600), 8'h00, 1'b1, 1'b0);
        add(1'b1, 1'b0, 1'b0, 32'h610, iw(32'h610), 8'h00, 1'b0, 1'b0, 32'h604, iw(32'h604), 8'h00, 1'b1, 1'b0);
        add(1'b1, 1'b0, 1'b0, 32'h614, iw(32'h614), 8'h00, 1'b1, 1'b0, 32'h604, iw(32'h604), 8'h00, 1'b1, 1'b1);
        add(1'b1, 1'b0, 1'b1, 32'h0,   32'h0,       8'h00, 1'b0, 1'b0, 32'h608, iw(32'h608), 8'h00, 1'b1, 1'b1);
        add(1'b1, 1'b0, 1'b1, 32'h0,   32'h0,       8'h00, 1'b0, 1'b0, 32'h60C, iw(32'h60C), 8'h00, 1'b1, 1'b1);
        add(1'b1, 1'b0, 1'b1, 32'h0,   32'h0,       8'h00, 1'b0, 1'b0, 32'h610, iw(32'h610), 8'h00, 1'b0, 1'b1);
        add(1'b1, 1'b0, 1'b1, 32'h0,   32'h0,       8'h00, 1'b0, 1'b1, 32'h0,   32'h0,       8'h00, 1'b0, 1'b1);
        add(1'b1, 1'b1, 1'b0, 32'h618, iw(32'h618), 8'h00, 1'b0, 1'b1, 32'h0,   32'h0,       8'h00, 1'b0, 1'b1);
        // clock enable low holds everything, including against flush
        add(1'b1, 1'b0, 1'b0, 32'h700, iw(32'h700), 8'h00, 1'b1, 1'b0, 32'h700, iw(32'h700), 8'h00, 1'b0, 1'b1);
        add(1'b0, 1'b0, 1'b0, 32'h704, iw(32'h704), 8'h00, 1'b0, 1'b0, 32'h700, iw(32'h700), 8'h00, 1'b0, 1'b1);
        add(1'b0, 1'b1, 1'b0, 32'h708, iw(32'h708), 8'h00, 1'b0, 1'b0, 32'h700, iw(32'h700), 8'h00, 1'b0, 1'b1);
        add(1'b1, 1'b0, 1'b1, 32'h0,   32'h0,       8'h00, 1'b0, 1'b1, 32'h0,   32'h0,       8'h00, 1'b0, 1'b1);

        drive(1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 8'h00, 1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", actual(), empty0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].en, vecs[i].fl, vecs[i].bub, vecs[i].pc, vecs[i].instr,
                  vecs[i].exc, vecs[i].ds);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), actual(), vecs[i].exp);
        end

        // no same-cycle bypass: head stays empty until the push edge
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 32'h800, iw(32'h800), 8'h00, 1'b1);
        #2;
        check("no_bypass", actual(), empty1);
        @(posedge clk);
        #1;
        check("push_latency", actual(), bundle(1'b0, 32'h800, iw(32'h800), 8'h00, 1'b0, 1'b1));
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 32'h804, iw(32'h804), 8'h00, 1'b1);
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 32'h808, iw(32'h808), 8'h00, 1'b1);
        @(posedge clk);
        #1;
        check("pre_reset_throttled", actual(), bundle(1'b0, 32'h800, iw(32'h800), 8'h00, 1'b1, 1'b1));

        // asynchronous reset between edges
        #2;
        rst = 1'b1;
        #1;
        check("async_reset", actual(), empty0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 8'h00, 1'b0);
        @(posedge clk);
        #1;
        check("post_reset_idle", actual(), empty0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction queue between the second fetch stage and decode. It captures each non-bubble packet (pc, instruction word, exception code) as it leaves fetch, holds up to DEPTH packets, and presents the oldest to decode. Because of its slack, a decode stall no longer has to propagate to fetch in the same cycle. It throttles fetch with a registered stall sized for the two fetch packets already in flight.

## Interface
- DEPTH, 4: queue entries; power of two, at least 4.
- SLACK, 2: packets that can still arrive after stall_out asserts (fetch pipeline depth).
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- clk_en  in  1  global clock enable; when low, all state holds.
- flush  in  1  discard queue contents and the incoming packet.
- bubble_in  in  1  incoming packet is empty.
- pc_in  in  32  pc of incoming packet.
- instr_in  in  32  instruction word returned by memory for pc_in.
- exc_in  in  8  exception code; 0 means none.
- decode_stall  in  1  decode cannot accept this cycle.
- bubble_out  out  1  head invalid (queue empty).
- pc_out  out  32  head pc.
- instr_out  out  32  head instruction.
- exc_out  out  8  head exception code.
- stall_out  out  1  registered stall to both fetch stages.
- overflow  out  1  sticky error flag; set on a push into a full queue.

## Operation
- push = clk_en & !flush & !bubble_in.
- pop = clk_en & !flush & !decode_stall & (count != 0).
- Storage: DEPTH-entry circular buffer with wr_ptr, rd_ptr ($clog2(DEPTH) bits, wrap naturally) and count ($clog2(DEPTH)+1 bits).
- Push writes {pc_in, instr_in, exc_in} at wr_ptr. When exc_in != 0, the stored instruction is 32'h0, so a faulting fetch never carries live instruction bits.
- Simultaneous push and pop: both pointers advance and count is unchanged. This is legal even at count == DEPTH.
- Push with count == DEPTH and no pop: packet dropped, state unchanged, overflow set to 1 until rst. This is an error case; it cannot occur when fetch honours stall_out.
- Head outputs are combinational from the entry at rd_ptr. When count == 0: bubble_out = 1 and pc_out, instr_out and exc_out are forced to 0.
- stall_out register: next value is (count_next >= DEPTH - SLACK), computed from the post-update count.
- flush (with clk_en): wr_ptr, rd_ptr and count go to 0, stall_out goes to 0, and the incoming packet is dropped. overflow is not cleared.
- No state machine beyond the occupancy counter. The queue states are EMPTY (count 0), PARTIAL and THROTTLED (count >= DEPTH-SLACK), derived from count only.

## Timing
- Reset values: count = 0, both pointers = 0, stall_out = 0, overflow = 0; bubble_out = 1; pc_out, instr_out and exc_out = 0.
- Latency: a packet pushed at edge t appears at the head after edge t (visible in cycle t+1) when the queue was empty. There is no same-cycle bypass.
- Pop takes effect at the edge where decode_stall is low. Decode samples head outputs before that edge.
- stall_out is asserted in the cycle after count reaches DEPTH-SLACK. Up to SLACK further packets may still arrive without overflow.
- flush beats push and pop in the same cycle. rst beats everything and is asynchronous.
- With clk_en low, pointers, count, stall_out and overflow hold, and the head outputs stay stable.

## Structure
- Shared package fetch_pkg holds:
  - the packet struct {pc[31:0], instr[31:0], exc[7:0]};
  - EXC_NONE = 8'h00;
  - EXC_MISALIGNED_PC = 8'h84;
  - the NOP word 32'h0.
- One sub-module, fetch_queue_ram: DEPTH x 72-bit storage with a single write port and a combinational read port; no reset on its contents.
- Pointer, count, stall and overflow logic live in fetch_queue.

## Test plan
- Reset, then push pc 0x400, 0x404, 0x408 with decode_stall = 0 -> heads appear one per cycle starting the cycle after each push; bubble_out = 0 only while count > 0.
- Hold decode_stall = 1 and push continuously -> stall_out rises the cycle after count = 2. Exactly 4 entries are held, overflow stays 0, and the drain order is 0x400..0x40C.
- Push pc 0x402 with exc_in = 8'h84 and instr_in = 32'hDEADBEEF -> the head shows exc_out = 8'h84, instr_out = 0, pc_out = 0x402.
- With 3 entries queued, assert flush together with a valid push -> the next cycle has bubble_out = 1, count = 0, stall_out = 0, and the pushed packet is lost.
- With a full queue, push and pop in the same cycle -> count stays 4 and the FIFO order is preserved. A push without a pop sets overflow = 1, and it stays set through a subsequent flush.
- Assert rst mid-burst, asynchronously between edges -> the outputs return immediately to their reset values: bubble_out = 1, stall_out = 0.
